// File: rtl/bram_lsu_rmw.sv
// ---------------------------------------------------------------------------
// bram_lsu_rmw
//
// Load/store front end for the byte-unaligned 2048-byte block RAM
// (bram_align1_2048). The RAM writes only whole 4-byte words at any byte
// address. Byte and halfword stores are therefore turned into
// read-modify-write sequences. Loads are extracted from the low bytes of the
// returned word and then sign- or zero-extended.
//
// Ports
//   clock       in   rising-edge clock
//   reset_n     in   asynchronous, active-low reset
//   req_valid   in   request present
//   req_ready   out  request accepted when req_valid && req_ready
//   req_addr    in   byte address, any alignment (wraps modulo 2^ADDR_WIDTH)
//   req_write   in   1 = store, 0 = load
//   req_size    in   0 = byte, 1 = half, 2/3 = word
//   req_signed  in   loads only: 1 = sign-extend, 0 = zero-extend
//   req_wdata   in   store data, right-justified
//   rsp_valid   out  one-cycle pulse per accepted request, in order
//   rsp_rdata   out  load result; 0 for store responses
//   ram_raddr   out  RAM read byte address
//   ram_waddr   out  RAM write byte address
//   ram_wdata   out  RAM write data; byte 0 lands at ram_waddr
//   ram_wsize   out  constant 4 (full-word write)
//   ram_wren    out  RAM write enable
//   ram_rdata   in   RAM read data, one cycle after ram_raddr
// ---------------------------------------------------------------------------
module bram_lsu_rmw #(
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_wdata,

    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,

    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [31:0]           ram_wdata,
    output logic [2:0]            ram_wsize,
    output logic                  ram_wren,
    input  logic [31:0]           ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_MERGE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic [15:0]           wdata_q;
    logic [31:0]           rsp_rdata_q;

    logic                  accept;
    logic                  store_word;
    logic [31:0]           load_ext;
    logic [31:0]           merge_data;

    // Ready is gated by reset_n so no request is taken (and no write is
    // issued) while reset is held, even though the state is already IDLE.
    assign req_ready  = reset_n && ((state_q == S_IDLE) || (state_q == S_RESP));
    assign accept     = req_valid && req_ready;
    // Size 3 is handled as a word, so bit 1 alone identifies a word access.
    assign store_word = req_write && req_size[1];

    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_rdata  = rsp_rdata_q;

    assign ram_raddr  = req_addr;
    assign ram_waddr  = (state_q == S_MERGE) ? addr_q : req_addr;
    assign ram_wdata  = (state_q == S_MERGE) ? merge_data : req_wdata;
    assign ram_wsize  = 3'd4;
    // MERGE drops out asynchronously on reset, so an in-flight RMW write
    // is abandoned without reaching the RAM.
    assign ram_wren   = (state_q == S_MERGE) || (accept && store_word);

    // Load extraction from the low bytes of the returned word.
    always_comb begin
        load_ext = ram_rdata;
        case (size_q)
            2'd0:    load_ext = {{24{signed_q & ram_rdata[7]}},  ram_rdata[7:0]};
            2'd1:    load_ext = {{16{signed_q & ram_rdata[15]}}, ram_rdata[15:0]};
            default: load_ext = ram_rdata;
        endcase
    end

    // Sub-word store: keep the upper RAM bytes, replace the low ones.
    always_comb begin
        merge_data = {ram_rdata[31:8], wdata_q[7:0]};
        if (size_q[0]) begin
            merge_data = {ram_rdata[31:16], wdata_q[15:0]};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            size_q      <= '0;
            signed_q    <= 1'b0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_RESP: begin
                    if (accept) begin
                        addr_q   <= req_addr;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        wdata_q  <= req_wdata[15:0];
                        if (!req_write) begin
                            state_q <= S_LOAD;
                        end else if (req_size[1]) begin
                            rsp_rdata_q <= '0;
                            state_q     <= S_RESP;
                        end else begin
                            state_q <= S_MERGE;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    rsp_rdata_q <= load_ext;
                    state_q     <= S_RESP;
                end
                S_MERGE: begin
                    rsp_rdata_q <= '0;
                    state_q     <= S_RESP;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_lsu_rmw.sv
module tb_bram_lsu_rmw;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [10:0] req_addr;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [10:0] ram_raddr;
    logic [10:0] ram_waddr;
    logic [31:0] ram_wdata;
    logic [2:0]  ram_wsize;
    logic        ram_wren;
    logic [31:0] ram_rdata;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    bram_lsu_rmw #(.ADDR_WIDTH(11)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .ram_raddr  (ram_raddr),
        .ram_waddr  (ram_waddr),
        .ram_wdata  (ram_wdata),
        .ram_wsize  (ram_wsize),
        .ram_wren   (ram_wren),
        .ram_rdata  (ram_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Byte-addressed RAM model: registered read of 4 wrapping bytes,
    // full-word write of 4 wrapping bytes. Reads see pre-edge contents.
    logic [7:0] mem [0:2047] = '{default: 8'h00};

    always @(posedge clock) begin
        ram_rdata <= {mem[ram_raddr + 11'd3], mem[ram_raddr + 11'd2],
                      mem[ram_raddr + 11'd1], mem[ram_raddr]};
        if (ram_wren) begin
            mem[ram_waddr]         <= ram_wdata[7:0];
            mem[ram_waddr + 11'd1] <= ram_wdata[15:8];
            mem[ram_waddr + 11'd2] <= ram_wdata[23:16];
            mem[ram_waddr + 11'd3] <= ram_wdata[31:24];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request from IDLE, then watch latency, response data and
    // the per-cycle wren pattern (bit i = wren i cycles after accept).
    task automatic op(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                      input logic [10:0] a, input logic [31:0] wd,
                      input int unsigned exp_lat, input logic [31:0] exp_rd,
                      input logic [3:0] exp_wren);
        int unsigned n;
        logic [3:0]  wren_seen;
        logic        got;
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        wren_seen  = '0;
        @(negedge clock);
        check_eq({tag, " ready"}, 32'(req_ready), 32'd1);
        wren_seen[0] = ram_wren;
        @(posedge clock);
        #1 req_valid = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 6) begin
            n++;
            @(negedge clock);
            if (n < 4) wren_seen = wren_seen | (4'(ram_wren) << n);
            if (rsp_valid) got = 1'b1;
        end
        check_eq({tag, " latency"}, got ? n : 32'd99, exp_lat);
        check_eq({tag, " rdata"}, rsp_rdata, exp_rd);
        check_eq({tag, " wren"}, 32'(wren_seen), 32'(exp_wren));
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    int unsigned pulses;
    logic [2:0]  exp_tab [7];

    initial begin
        // Reset: present a word store that must be ignored while in reset.
        reset_n    = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_addr   = 11'h005;
        req_wdata  = 32'hFFFF_FFFF;
        #2;
        check_eq("rst ready", 32'(req_ready), 32'd0);
        check_eq("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst rsp_rdata", rsp_rdata, 32'd0);
        check_eq("rst wren", 32'(ram_wren), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        check_eq("rst wren held", 32'(ram_wren), 32'd0);
        check_eq("wsize", 32'(ram_wsize), 32'd4);
        req_valid = 1'b0;
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1;
        check_eq("rst no write", 32'(mem[5]), 32'd0);

        // Word store then signed word load at an unaligned address.
        op("st_w 003", 1'b1, 2'd2, 1'b0, 11'h003, 32'hDEADBEEF, 1, 32'h0, 4'b0001);
        op("ld_w 003", 1'b0, 2'd2, 1'b1, 11'h003, 32'h0, 2, 32'hDEADBEEF, 4'b0000);

        // Byte RMW into an existing word; upper wdata bits must be ignored.
        op("st_w 010", 1'b1, 2'd3, 1'b0, 11'h010, 32'h44332211, 1, 32'h0, 4'b0001);
        op("st_b 011", 1'b1, 2'd0, 1'b0, 11'h011, 32'hFFFFFFAA, 2, 32'h0, 4'b0010);
        op("ld_w 010", 1'b0, 2'd2, 1'b0, 11'h010, 32'h0, 2, 32'h4433AA11, 4'b0000);
        check_eq("mem 014 kept", 32'(mem[11'h014]), 32'h00);

        // Sign and zero extension.
        op("st_b 020", 1'b1, 2'd0, 1'b0, 11'h020, 32'h12345680, 2, 32'h0, 4'b0010);
        op("st_b 021", 1'b1, 2'd0, 1'b0, 11'h021, 32'h0000007F, 2, 32'h0, 4'b0010);
        op("ld_bs 020", 1'b0, 2'd0, 1'b1, 11'h020, 32'h0, 2, 32'hFFFFFF80, 4'b0000);
        op("ld_bu 020", 1'b0, 2'd0, 1'b0, 11'h020, 32'h0, 2, 32'h00000080, 4'b0000);
        op("ld_hs 020", 1'b0, 2'd1, 1'b1, 11'h020, 32'h0, 2, 32'h00007F80, 4'b0000);

        // Half store wrapping past the top of memory.
        op("st_h 7FF", 1'b1, 2'd1, 1'b0, 11'h7FF, 32'hAAAABEEF, 2, 32'h0, 4'b0010);
        op("ld_hu 7FF", 1'b0, 2'd1, 1'b0, 11'h7FF, 32'h0, 2, 32'h0000BEEF, 4'b0000);
        op("ld_hs 7FF", 1'b0, 2'd1, 1'b1, 11'h7FF, 32'h0, 2, 32'hFFFFBEEF, 4'b0000);
        op("ld_bu 000", 1'b0, 2'd0, 1'b0, 11'h000, 32'h0, 2, 32'h000000BE, 4'b0000);
        op("ld_bs 000", 1'b0, 2'd0, 1'b1, 11'h000, 32'h0, 2, 32'hFFFFFFBE, 4'b0000);
        check_eq("mem 001 kept", 32'(mem[11'h001]), 32'h00);

        // Back-to-back: word store (c0), byte store (c1), load held c2..c3.
        // Table: {ready, rsp_valid, wren} per cycle.
        exp_tab = '{3'b101, 3'b110, 3'b001, 3'b110, 3'b000, 3'b110, 3'b100};
        pulses = 0;
        for (int c = 0; c < 7; c++) begin
            req_valid  = (c < 4);
            req_signed = 1'b0;
            if (c == 0) begin
                req_write = 1'b1; req_size = 2'd2; req_addr = 11'h040; req_wdata = 32'h11223344;
            end else if (c == 1) begin
                req_write = 1'b1; req_size = 2'd0; req_addr = 11'h041; req_wdata = 32'h00000055;
            end else begin
                req_write = 1'b0; req_size = 2'd2; req_addr = 11'h040; req_wdata = 32'h0;
            end
            @(negedge clock);
            check_eq($sformatf("b2b c%0d ready", c), 32'(req_ready), 32'(exp_tab[c][2]));
            check_eq($sformatf("b2b c%0d rsp_valid", c), 32'(rsp_valid), 32'(exp_tab[c][1]));
            check_eq($sformatf("b2b c%0d wren", c), 32'(ram_wren), 32'(exp_tab[c][0]));
            if (rsp_valid) pulses++;
            if (c == 1 || c == 3) check_eq($sformatf("b2b c%0d store rdata", c), rsp_rdata, 32'h0);
            if (c == 2) begin
                check_eq("b2b merge waddr", 32'(ram_waddr), 32'h041);
                check_eq("b2b merge wdata", ram_wdata, 32'h00112255);
            end
            if (c == 5) check_eq("b2b load rdata", rsp_rdata, 32'h11225544);
            @(posedge clock);
            #1;
        end
        check_eq("b2b pulses", pulses, 32'd3);

        // Reset during MERGE abandons the write.
        op("st_w 050", 1'b1, 2'd2, 1'b0, 11'h050, 32'hCAFEF00D, 1, 32'h0, 4'b0001);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr  = 11'h050; req_wdata = 32'h00000099;
        @(posedge clock);
        #1 req_valid = 1'b0;
        #1;
        check_eq("merge wren", 32'(ram_wren), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("abort wren", 32'(ram_wren), 32'd0);
        check_eq("abort rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        #1;
        check_eq("post rst rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("post rst ready", 32'(req_ready), 32'd1);
        check_eq("post rst wren", 32'(ram_wren), 32'd0);
        @(posedge clock);
        #1;
        check_eq("post rst no rsp", 32'(rsp_valid), 32'd0);
        check_eq("abort mem 050", 32'(mem[11'h050]), 32'h0D);
        op("ld_w 050", 1'b0, 2'd2, 1'b0, 11'h050, 32'h0, 2, 32'hCAFEF00D, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
